// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM encoding for the UART command controller.
// Frame layout: HEADER, CMD, ADDR, DATA, CSUM.
package uart_cmd_pkg;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] ACK_BYTE = 8'h55;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_CMD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM,
    ST_EXEC,
    ST_RD_CAP,
    ST_TX_WAIT
  } state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return cmd + addr + data;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: clears on i_clr or while disabled, counts while
// enabled, and flags o_expire in the cycle the count reaches TIMEOUT_CYC-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 156250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [17:0] LAST_CNT = 18'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 262144) begin : g_bad_timeout
    $error("uart_cmd_timeout: TIMEOUT_CYC must be in 2..262144");
  end

  logic [17:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || !i_en) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 18'd1;
    end
  end

  assign o_expire = i_en && (r_count == LAST_CNT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: decodes 5-byte frames into register
// writes/reads and returns a one-byte ACK, NAK or read-data reply.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 156250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cmd;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [7:0]  r_csum;
  logic [7:0]  r_tx_data;
  logic [1:0]  r_err_code;

  logic        w_in_get;
  logic        w_expire;
  logic        w_timeout;
  logic        w_csum_ok;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_tx_start;
  logic        w_frame_err;
  logic [1:0]  w_err_val;

  assign w_in_get  = (r_state == ST_GET_CMD) || (r_state == ST_GET_ADDR) ||
                     (r_state == ST_GET_DATA) || (r_state == ST_GET_CSUM);
  assign w_csum_ok = (frame_csum(r_cmd, r_addr, r_data) == r_csum);
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign w_timeout = w_expire && !rx_done;

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (rx_done),
    .i_en    (w_in_get),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_tx_start   = 1'b0;
    w_frame_err  = 1'b0;
    w_err_val    = r_err_code;
    case (r_state)
      ST_IDLE:     if (rx_done && rx_data == HEADER) w_state_next = ST_GET_CMD;
      ST_GET_CMD:  if (rx_done) w_state_next = ST_GET_ADDR;
      ST_GET_ADDR: if (rx_done) w_state_next = ST_GET_DATA;
      ST_GET_DATA: if (rx_done) w_state_next = ST_GET_CSUM;
      ST_GET_CSUM: if (rx_done) w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (!w_csum_ok) begin
          w_frame_err  = 1'b1;
          w_err_val    = ERR_CSUM;
          w_state_next = ST_TX_WAIT;
        end else if (r_cmd == CMD_WR) begin
          w_wr_en      = 1'b1;
          w_state_next = ST_TX_WAIT;
        end else if (r_cmd == CMD_RD) begin
          w_rd_en      = 1'b1;
          w_state_next = ST_RD_CAP;
        end else begin
          w_frame_err  = 1'b1;
          w_err_val    = ERR_CMD;
          w_state_next = ST_TX_WAIT;
        end
      end
      ST_RD_CAP:   w_state_next = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (!tx_busy) begin
          w_tx_start   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default:     w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_frame_err  = 1'b1;
      w_err_val    = ERR_TIMEOUT;
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_err_code <= '0;
    end else begin
      r_state <= w_state_next;
      if (rx_done) begin
        case (r_state)
          ST_GET_CMD:  r_cmd  <= rx_data;
          ST_GET_ADDR: r_addr <= rx_data;
          ST_GET_DATA: r_data <= rx_data;
          ST_GET_CSUM: r_csum <= rx_data;
          default:     ;
        endcase
      end
      // Reads leave tx_data alone here; RD_CAP loads the returned byte.
      if (r_state == ST_EXEC) begin
        if (w_wr_en)       r_tx_data <= ACK_BYTE;
        else if (!w_rd_en) r_tx_data <= NAK_BYTE;
      end else if (r_state == ST_RD_CAP) begin
        r_tx_data <= reg_rdata;
      end
      if (w_frame_err) r_err_code <= w_err_val;
    end
  end

  assign reg_addr  = r_addr;
  assign reg_wdata = r_data;
  assign reg_wr_en = w_wr_en;
  assign reg_rd_en = w_rd_en;
  assign tx_data   = r_tx_data;
  assign tx_start  = w_tx_start;
  assign frame_err = w_frame_err;
  assign err_code  = w_frame_err ? w_err_val : r_err_code;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-bus slave and pulse counters.
  logic [7:0] slave_mem [256];
  logic [7:0] model_mem [256];
  logic       rd_pending = 1'b0;
  logic [7:0] rd_addr;
  int mon_wr = 0, mon_rd = 0, mon_tx = 0, mon_err = 0;
  int exp_wr = 0, exp_rd = 0, exp_tx = 0, exp_err = 0;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      mon_wr++;
      slave_mem[reg_addr] = reg_wdata;
    end
    if (reg_rd_en) begin
      mon_rd++;
      rd_pending = 1'b1;
      rd_addr    = reg_addr;
    end
    if (tx_start)  mon_tx++;
    if (frame_err) mon_err++;
  end

  // Read data is valid only in the cycle after reg_rd_en; junk otherwise.
  always @(posedge clk) begin
    #1;
    if (rd_pending) begin
      reg_rdata  = slave_mem[rd_addr];
      rd_pending = 1'b0;
    end else begin
      reg_rdata = 8'($urandom);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] csum,
                           input int gap, input int addr_gap, input int busy_cyc);
    logic [7:0] sum, reply;
    logic [1:0] code;
    bit is_err, is_wr, is_rd, seen;
    int base, k_exp;
    sum = 8'((int'(cmd) + int'(addr) + int'(data)) % 256);
    is_err = 0; is_wr = 0; is_rd = 0; code = 2'b00; base = 2;
    if (sum != csum) begin
      is_err = 1; code = 2'b01; reply = 8'hEE;
    end else if (cmd == 8'h01) begin
      is_wr = 1; reply = 8'h55; model_mem[addr] = data;
    end else if (cmd == 8'h02) begin
      is_rd = 1; reply = model_mem[addr]; base = 3;
    end else begin
      is_err = 1; code = 2'b10; reply = 8'hEE;
    end
    exp_wr += int'(is_wr); exp_rd += int'(is_rd); exp_err += int'(is_err); exp_tx++;
    k_exp = (busy_cyc + 1 > base) ? busy_cyc + 1 : base;
    $display("frame cmd=%02h addr=%02h data=%02h csum=%02h busy=%0d -> reply %02h",
             cmd, addr, data, csum, busy_cyc, reply);

    send_byte(8'hA5, gap);
    send_byte(cmd, gap);
    send_byte(addr, addr_gap);
    send_byte(data, gap);
    send_byte(csum, gap);

    seen = 0;
    for (int k = 1; k <= busy_cyc + 10 && !seen; k++) begin
      tx_busy = (k <= busy_cyc);
      @(negedge clk);
      if (k == 1) begin
        check_eq("exec_wr_en", reg_wr_en, is_wr);
        check_eq("exec_rd_en", reg_rd_en, is_rd);
        check_eq("exec_frame_err", frame_err, is_err);
        if (is_err) check_eq("exec_err_code", err_code, code);
        if (is_wr || is_rd) check_eq("exec_addr", reg_addr, addr);
        if (is_wr) check_eq("exec_wdata", reg_wdata, data);
      end
      if (tx_start) begin
        seen = 1;
        check_eq("tx_start_cycle", k, k_exp);
        check_eq("tx_data", tx_data, reply);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      check_eq("tx_start_seen", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      tx_busy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("tx_data_hold", tx_data, reply);
      check_eq("idle_after_tx", busy, 0);
      @(posedge clk);
      #1;
    end
    tx_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd, addr, data, csum, junk;
    int snap_wr, snap_rd, snap_tx, snap_err;
    bit seen;

    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; reg_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_start,
              frame_err, err_code, busy}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames: write, read-back, bad checksum, bad command, junk prefix.
    run_frame(8'h01, 8'h10, 8'h3C, 8'h4D, 0, 0, 0);
    run_frame(8'h01, 8'h20, 8'h9A, 8'hBB, 1, 1, 0);
    run_frame(8'h02, 8'h20, 8'h00, 8'h22, 0, 0, 0);
    run_frame(8'h01, 8'h10, 8'h3C, 8'h00, 0, 0, 0);
    run_frame(8'h07, 8'h00, 8'h00, 8'h07, 0, 0, 0);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    run_frame(8'h01, 8'h10, 8'h3C, 8'h4D, 0, 0, 0);

    // Inter-byte timeout after the CMD byte.
    send_byte(8'hA5, 2);
    send_byte(8'h01, 0);
    seen = 0;
    for (int k = 1; k <= TO + 10 && !seen; k++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = 1;
        check_eq("timeout_cycle", k, TO);
        check_eq("timeout_code", err_code, 2'b11);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) check_eq("timeout_seen", 0, 1);
    exp_err++;
    $display("timeout frame aborted");
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("timeout_idle", busy, 0);
    check_eq("err_code_hold", err_code, 2'b11);
    @(posedge clk);
    #1;

    // Byte landing exactly on the expiry cycle wins; frame completes normally.
    run_frame(8'h01, 8'h44, 8'h12, 8'h57, 0, TO - 1, 0);
    // Transmitter busy for 50 cycles.
    run_frame(8'h01, 8'h10, 8'h3C, 8'h4D, 0, 0, 50);

    // Reset after the ADDR byte discards the frame.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midframe_reset_outputs",
             {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_start,
              frame_err, err_code, busy}, 32'h0);
    snap_wr = mon_wr; snap_rd = mon_rd; snap_tx = mon_tx; snap_err = mon_err;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h3C, 0);
    send_byte(8'h4D, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("post_reset_pulses", (mon_wr - snap_wr) + (mon_rd - snap_rd) +
             (mon_tx - snap_tx) + (mon_err - snap_err), 0);
    check_eq("post_reset_idle", busy, 0);
    $display("mid-frame reset applied");
    // Register contents were lost with the reset only in the DUT's regs,
    // the slave memory persists, so the model keeps its view too.
    @(posedge clk);
    #1;

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      cmd  = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      addr = 8'($urandom_range(0, 7));
      data = 8'($urandom);
      csum = 8'((int'(cmd) + int'(addr) + int'(data)) % 256);
      if ($urandom_range(0, 4) == 0) csum = csum ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, $urandom_range(0, 3));
      end
      run_frame(cmd, addr, data, csum, $urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0);
    end

    check_eq("total_writes", mon_wr, exp_wr);
    check_eq("total_reads", mon_rd, exp_rd);
    check_eq("total_tx_starts", mon_tx, exp_tx);
    check_eq("total_frame_errs", mon_err, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
